// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time,
// with round-robin arbitration on contention and a fixed programmable access latency.
module mem_port_arbiter #(
  parameter int unsigned LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,

  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  input  logic        ifu_resp_ready,
  output logic [31:0] ifu_rdata,

  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic [7:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  input  logic        lsu_resp_ready,
  output logic [31:0] lsu_rdata,

  output logic        mem_ld_wen,
  output logic        mem_st_wen,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask
);

  localparam logic [3:0] LatCnt = 4'(LATENCY);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StAccess,
    StResp
  } state_e;

  typedef enum logic {
    OwnIfu = 1'b0,
    OwnLsu = 1'b1
  } owner_e;

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  owner_e      last_owner_q, last_owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [31:0] wdata_q, wdata_d;
  logic [7:0]  wmask_q, wmask_d;
  logic [31:0] rdata_q, rdata_d;

  logic        grant_ifu;
  logic        grant_lsu;
  logic        owner_resp_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      owner_q      <= OwnIfu;
      last_owner_q <= OwnIfu;
      cnt_q        <= 4'd0;
      addr_q       <= 32'd0;
      wen_q        <= 1'b0;
      wdata_q      <= 32'd0;
      wmask_q      <= 8'd0;
      rdata_q      <= 32'd0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wmask_q      <= wmask_d;
      rdata_q      <= rdata_d;
    end
  end

  assign owner_resp_ready = (owner_q == OwnLsu) ? lsu_resp_ready : ifu_resp_ready;

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    last_owner_d   = last_owner_q;
    cnt_d          = cnt_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    rdata_d        = rdata_q;
    grant_ifu      = 1'b0;
    grant_lsu      = 1'b0;
    mem_ld_wen     = 1'b0;
    mem_st_wen     = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;

    unique case (state_q)
      StIdle: begin
        // On contention the requester that did not win last time gets the port.
        if (ifu_req_valid && lsu_req_valid) begin
          grant_lsu = (last_owner_q == OwnIfu);
          grant_ifu = !grant_lsu;
        end else begin
          grant_ifu = ifu_req_valid;
          grant_lsu = lsu_req_valid;
        end

        if (grant_ifu || grant_lsu) begin
          owner_d      = grant_lsu ? OwnLsu : OwnIfu;
          last_owner_d = grant_lsu ? OwnLsu : OwnIfu;
          addr_d       = grant_lsu ? lsu_addr : ifu_addr;
          wen_d        = grant_lsu & lsu_wen;
          wdata_d      = grant_lsu ? lsu_wdata : 32'd0;
          wmask_d      = grant_lsu ? lsu_wmask : 8'd0;
          cnt_d        = LatCnt;
          state_d      = (LatCnt != 4'd0) ? StWait : StAccess;
        end
      end

      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = StAccess;
        end
      end

      StAccess: begin
        mem_ld_wen = !wen_q;
        mem_st_wen = wen_q;
        rdata_d    = wen_q ? 32'd0 : mem_rdata;
        state_d    = StResp;
      end

      StResp: begin
        ifu_resp_valid = (owner_q == OwnIfu);
        lsu_resp_valid = (owner_q == OwnLsu);
        if (owner_resp_ready) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign ifu_req_ready = grant_ifu;
  assign lsu_req_ready = grant_lsu;

  assign ifu_rdata = (owner_q == OwnIfu) ? rdata_q : 32'd0;
  assign lsu_rdata = (owner_q == OwnLsu) ? rdata_q : 32'd0;

  // Address/data always reflect the latched request; only the enables qualify them.
  assign mem_raddr = addr_q;
  assign mem_waddr = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_wmask = wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized scoreboard bench for mem_port_arbiter against a cycle-count reference model.
module tb_mem_port_arbiter;

  localparam int unsigned LAT = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ifu_req_valid = 1'b0;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr = 32'd0;
  logic        ifu_resp_valid;
  logic        ifu_resp_ready = 1'b1;
  logic [31:0] ifu_rdata;
  logic        lsu_req_valid = 1'b0;
  logic        lsu_req_ready;
  logic        lsu_wen = 1'b0;
  logic [31:0] lsu_addr = 32'd0;
  logic [31:0] lsu_wdata = 32'd0;
  logic [7:0]  lsu_wmask = 8'd0;
  logic        lsu_resp_valid;
  logic        lsu_resp_ready = 1'b1;
  logic [31:0] lsu_rdata;
  logic        mem_ld_wen;
  logic        mem_st_wen;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [7:0]  mem_wmask;

  mem_port_arbiter #(.LATENCY(LAT)) dut (
    .clock          (clock),
    .reset          (reset),
    .ifu_req_valid  (ifu_req_valid),
    .ifu_req_ready  (ifu_req_ready),
    .ifu_addr       (ifu_addr),
    .ifu_resp_valid (ifu_resp_valid),
    .ifu_resp_ready (ifu_resp_ready),
    .ifu_rdata      (ifu_rdata),
    .lsu_req_valid  (lsu_req_valid),
    .lsu_req_ready  (lsu_req_ready),
    .lsu_wen        (lsu_wen),
    .lsu_addr       (lsu_addr),
    .lsu_wdata      (lsu_wdata),
    .lsu_wmask      (lsu_wmask),
    .lsu_resp_valid (lsu_resp_valid),
    .lsu_resp_ready (lsu_resp_ready),
    .lsu_rdata      (lsu_rdata),
    .mem_ld_wen     (mem_ld_wen),
    .mem_st_wen     (mem_st_wen),
    .mem_raddr      (mem_raddr),
    .mem_rdata      (mem_rdata),
    .mem_waddr      (mem_waddr),
    .mem_wdata      (mem_wdata),
    .mem_wmask      (mem_wmask)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return {a[15:0], a[31:16]} ^ 32'h5a5a_3c3c;
  endfunction

  // Read data is only meaningful in the enable cycle; garbage otherwise.
  assign mem_rdata = mem_ld_wen ? mem_fn(mem_raddr) : 32'hbad0_bad0;

  typedef struct {
    int          cyc;
    logic        st;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  wmask;
  } mem_item_t;

  typedef struct {
    int          start;
    logic        lsu;
    logic [31:0] data;
  } resp_item_t;

  mem_item_t  mem_q[$];
  resp_item_t resp_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model state
  bit m_busy = 1'b0;
  bit m_owner_lsu = 1'b0;
  bit m_last_lsu = 1'b0;
  int m_resp_start = 0;
  int m_acc_cyc = 0;
  bit ifu_acc = 1'b0;
  bit lsu_acc = 1'b0;
  bit resp_seen = 1'b0;
  int stall_cycles = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input string info);
    checks++;
    errors++;
    $display("FAIL %s: %s (cycle %0d)", name, info, cyc);
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Reference model: arbitration and timing from cycle arithmetic.
  always @(negedge clock) begin : model
    logic        win_lsu;
    logic        e_ifu;
    logic        e_lsu;
    mem_item_t   mi;
    resp_item_t  ri;
    e_ifu   = 1'b0;
    e_lsu   = 1'b0;
    ifu_acc = 1'b0;
    lsu_acc = 1'b0;
    if (!reset) begin
      mem_q.delete();
      resp_q.delete();
      m_busy     = 1'b0;
      m_last_lsu = 1'b0;
    end else if (m_busy) begin
      if (cyc >= m_resp_start && (m_owner_lsu ? lsu_resp_ready : ifu_resp_ready)) m_busy = 1'b0;
    end else if (ifu_req_valid || lsu_req_valid) begin
      win_lsu = lsu_req_valid && (!ifu_req_valid || !m_last_lsu);
      e_lsu   = win_lsu;
      e_ifu   = !win_lsu;
      lsu_acc = win_lsu;
      ifu_acc = !win_lsu;
      mi.cyc   = cyc + 1 + int'(LAT);
      mi.st    = win_lsu ? lsu_wen : 1'b0;
      mi.addr  = win_lsu ? lsu_addr : ifu_addr;
      mi.wdata = win_lsu ? lsu_wdata : 32'd0;
      mi.wmask = win_lsu ? lsu_wmask : 8'd0;
      mem_q.push_back(mi);
      ri.start = cyc + 2 + int'(LAT);
      ri.lsu   = win_lsu;
      ri.data  = mi.st ? 32'd0 : mem_fn(mi.addr);
      resp_q.push_back(ri);
      m_busy       = 1'b1;
      m_owner_lsu  = win_lsu;
      m_last_lsu   = win_lsu;
      m_acc_cyc    = cyc;
      m_resp_start = ri.start;
    end
    check("ifu_req_ready", {31'd0, ifu_req_ready}, {31'd0, e_ifu});
    check("lsu_req_ready", {31'd0, lsu_req_ready}, {31'd0, e_lsu});
  end

  // Monitor: pops expected items when the DUT presents memory or response activity.
  always @(negedge clock) begin : monitor
    mem_item_t  it;
    resp_item_t r;
    if (!reset) begin
      resp_seen = 1'b0;
    end
    if (mem_ld_wen || mem_st_wen) begin
      if (mem_q.size() == 0) begin
        fail("mem_unexpected", $sformatf("ld=%0b st=%0b with nothing expected", mem_ld_wen,
             mem_st_wen));
      end else begin
        it = mem_q.pop_front();
        check("mem_cycle", cyc, it.cyc);
        check("mem_ld_wen", {31'd0, mem_ld_wen}, {31'd0, !it.st});
        check("mem_st_wen", {31'd0, mem_st_wen}, {31'd0, it.st});
        if (it.st) begin
          check("mem_waddr", mem_waddr, it.addr);
          check("mem_wdata", mem_wdata, it.wdata);
          check("mem_wmask", {24'd0, mem_wmask}, {24'd0, it.wmask});
        end else begin
          check("mem_raddr", mem_raddr, it.addr);
        end
      end
    end else if (mem_q.size() > 0 && mem_q[0].cyc <= cyc) begin
      fail("mem_missing", $sformatf("no enable, access expected at cycle %0d", mem_q[0].cyc));
      void'(mem_q.pop_front());
    end

    if (ifu_resp_valid || lsu_resp_valid) begin
      if (resp_q.size() == 0) begin
        fail("resp_unexpected", $sformatf("ifu_v=%0b lsu_v=%0b with nothing expected",
             ifu_resp_valid, lsu_resp_valid));
      end else begin
        r = resp_q[0];
        if (!resp_seen) begin
          check("resp_start", cyc, r.start);
          resp_seen = 1'b1;
        end
        check("ifu_resp_valid", {31'd0, ifu_resp_valid}, {31'd0, !r.lsu});
        check("lsu_resp_valid", {31'd0, lsu_resp_valid}, {31'd0, r.lsu});
        check("resp_rdata", r.lsu ? lsu_rdata : ifu_rdata, r.data);
        if (r.lsu ? lsu_resp_ready : ifu_resp_ready) begin
          void'(resp_q.pop_front());
          resp_seen = 1'b0;
        end
      end
    end else if (resp_q.size() > 0 && (resp_seen || resp_q[0].start <= cyc)) begin
      fail("resp_missing", $sformatf("response expected from cycle %0d", resp_q[0].start));
      void'(resp_q.pop_front());
      resp_seen = 1'b0;
    end
  end

  // mode 0: no new requests; 1: random traffic; 2: both requesters always valid
  task automatic step(input int mode);
    @(posedge clock);
    #1;
    if (ifu_acc) ifu_req_valid = 1'b0;
    if (lsu_acc) lsu_req_valid = 1'b0;
    ifu_resp_ready = 1'b1;
    lsu_resp_ready = 1'b1;
    if (mode == 1) begin
      if (!ifu_req_valid && $urandom_range(0, 2) == 0) begin
        ifu_req_valid = 1'b1;
        ifu_addr      = $urandom & 32'hffff_fffc;
      end
      if (!lsu_req_valid && $urandom_range(0, 2) == 0) begin
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'($urandom_range(0, 1));
        lsu_addr      = $urandom;
        lsu_wdata     = $urandom;
        lsu_wmask     = 8'($urandom);
      end
      ifu_resp_ready = ($urandom_range(0, 3) != 0);
      lsu_resp_ready = ($urandom_range(0, 3) != 0);
    end else if (mode == 2) begin
      if (!ifu_req_valid) begin
        ifu_req_valid = 1'b1;
        ifu_addr      = $urandom & 32'hffff_fffc;
      end
      if (!lsu_req_valid) begin
        lsu_req_valid = 1'b1;
        lsu_wen       = 1'($urandom_range(0, 1));
        lsu_addr      = $urandom;
        lsu_wdata     = $urandom;
        lsu_wmask     = 8'($urandom);
      end
    end
    if (stall_cycles > 0 && m_busy && m_owner_lsu && cyc >= m_resp_start) begin
      lsu_resp_ready = 1'b0;
      stall_cycles--;
    end
  endtask

  task automatic apply_reset();
    reset         = 1'b0;
    ifu_req_valid = 1'b0;
    lsu_req_valid = 1'b0;
    stall_cycles  = 0;
    #1;
    check("rst_ifu_req_ready", {31'd0, ifu_req_ready}, 32'd0);
    check("rst_lsu_req_ready", {31'd0, lsu_req_ready}, 32'd0);
    check("rst_ifu_resp_valid", {31'd0, ifu_resp_valid}, 32'd0);
    check("rst_lsu_resp_valid", {31'd0, lsu_resp_valid}, 32'd0);
    check("rst_mem_ld_wen", {31'd0, mem_ld_wen}, 32'd0);
    check("rst_mem_st_wen", {31'd0, mem_st_wen}, 32'd0);
    check("rst_mem_raddr", mem_raddr, 32'd0);
    check("rst_mem_waddr", mem_waddr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_mem_wmask", {24'd0, mem_wmask}, 32'd0);
    check("rst_ifu_rdata", ifu_rdata, 32'd0);
    check("rst_lsu_rdata", lsu_rdata, 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic wait_ifu_accept(input string name);
    for (int i = 0; i < 60 && ifu_req_valid; i++) step(0);
    if (ifu_req_valid) fail(name, "ifu request never accepted");
  endtask

  task automatic wait_lsu_accept(input string name);
    for (int i = 0; i < 60 && lsu_req_valid; i++) step(0);
    if (lsu_req_valid) fail(name, "lsu request never accepted");
  endtask

  initial begin : main
    bit found;
    #2;
    apply_reset();

    // Both requesters continuously valid: grants must alternate starting with LSU.
    repeat (30) step(2);
    repeat (30) step(0);

    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    wait_ifu_accept("ifu_read_timeout");
    repeat (10) step(0);

    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b1;
    lsu_addr      = 32'h8000_0100;
    lsu_wdata     = 32'hdead_beef;
    lsu_wmask     = 8'h0f;
    wait_lsu_accept("lsu_store_timeout");
    repeat (10) step(0);

    // Load whose response is stalled for 5 cycles while a fetch waits behind it.
    stall_cycles  = 5;
    lsu_req_valid = 1'b1;
    lsu_wen       = 1'b0;
    lsu_addr      = 32'h8000_0040;
    wait_lsu_accept("lsu_load_timeout");
    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0004;
    wait_ifu_accept("ifu_after_stall_timeout");
    check("stall_applied", stall_cycles, 32'd0);
    repeat (10) step(0);

    repeat (400) step(1);
    repeat (40) step(0);
    repeat (20) step(0);

    // Reset while a transaction sits in the latency wait.
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      step(2);
      if (m_busy && cyc == m_acc_cyc + 1) found = 1'b1;
    end
    if (found) apply_reset();
    else fail("reset_window_timeout", "never observed a transaction in its wait window");
    repeat (10) step(0);

    ifu_req_valid = 1'b1;
    ifu_addr      = 32'h8000_0000;
    wait_ifu_accept("ifu_post_reset_timeout");
    repeat (10) step(0);

    repeat (300) step(1);
    repeat (40) step(0);

    check("mem_q_drained", mem_q.size(), 32'd0);
    check("resp_q_drained", resp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
